// File: rtl/ysyx_22050039_ifetch_buf_if.sv
// Fetch-side bus bundle: instruction-memory request/response, decoder handshake and redirect.
interface ysyx_22050039_ifetch_buf_if #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned INST_LEN = 32
);
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [XLEN-1:0]     imem_req_addr;
  logic                imem_resp_valid;
  logic [INST_LEN-1:0] imem_resp_data;
  logic                inst_valid;
  logic                inst_ready;
  logic [INST_LEN-1:0] inst;
  logic [XLEN-1:0]     inst_pc;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );

  // Memory / decoder / EXU side
  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_22050039_ifetch_buf.sv
// In-order instruction fetch with credit-limited requests, a small {pc, inst} FIFO
// and redirect flush that discards responses of requests already in flight.
module ysyx_22050039_ifetch_buf #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     INST_LEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  ysyx_22050039_ifetch_buf_if.master bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [INST_LEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] resp_pc, resp_pc_n;
  logic [CW-1:0]   outst, outst_n;
  logic [CW-1:0]   drop, drop_n;
  logic [CW-1:0]   count, count_n;
  logic [PW-1:0]   rd_ptr, rd_ptr_n;
  logic [PW-1:0]   wr_ptr, wr_ptr_n;
  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            resp_fire;
  logic            push;
  logic            pop;
  entry_t          head;
  entry_t          mem [DEPTH];

  // Credit covers both in-flight requests and buffered words, so a push never overflows
  assign credit_used        = (CW+1)'(outst) + (CW+1)'(count);
  assign bus.imem_req_valid = !rst && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = fetch_pc;
  assign head               = mem[rd_ptr];
  assign bus.inst_valid     = !rst && (count != '0) && !bus.redirect_valid;
  assign bus.inst           = rst ? '0 : head.inst;
  assign bus.inst_pc        = rst ? '0 : head.pc;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign resp_fire          = bus.imem_resp_valid && (outst != '0);
  assign pop                = bus.inst_valid && bus.inst_ready;

  // Next-state: redirect overrides every other same-cycle update
  always_comb begin
    fetch_pc_n = fetch_pc;
    resp_pc_n  = resp_pc;
    drop_n     = drop;
    count_n    = count;
    rd_ptr_n   = rd_ptr;
    wr_ptr_n   = wr_ptr;
    push       = 1'b0;
    outst_n    = outst + CW'(req_fire) - CW'(resp_fire);
    if (bus.redirect_valid) begin
      fetch_pc_n = bus.redirect_pc & ~XLEN'(3);
      resp_pc_n  = bus.redirect_pc & ~XLEN'(3);
      drop_n     = outst_n;
      count_n    = '0;
      rd_ptr_n   = '0;
      wr_ptr_n   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_n = fetch_pc + XLEN'(4);
      end
      if (resp_fire) begin
        if (drop != '0) begin
          drop_n = drop - CW'(1);
        end else begin
          push      = 1'b1;
          resp_pc_n = resp_pc + XLEN'(4);
        end
      end
      if (push) begin
        wr_ptr_n = wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr_n = rd_ptr + PW'(1);
      end
      count_n = count + CW'(push) - CW'(pop);
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      fetch_pc <= fetch_pc_n;
      resp_pc  <= resp_pc_n;
      outst    <= outst_n;
      drop     <= drop_n;
      count    <= count_n;
      rd_ptr   <= rd_ptr_n;
      wr_ptr   <= wr_ptr_n;
    end
  end

  // FIFO storage; cleared on reset so an empty head reads as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= '{pc: resp_pc, inst: bus.imem_resp_data};
    end
  end
endmodule

// File: tb/tb_ysyx_22050039_ifetch_buf.sv
// Bench for the fetch buffer: cycle-exact directed table, redirect sequences,
// then randomized traffic against a stream-level reference model.
module tb_ysyx_22050039_ifetch_buf;
  localparam logic [63:0] B = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_22050039_ifetch_buf_if bus ();

  ysyx_22050039_ifetch_buf dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, rr, rv;
    logic [31:0] rdata;
    logic        ir, rd;
    logic [63:0] rpc;
    logic        e_rv;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [63:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t        tbl[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          pops = 0;
  logic [63:0] exp_fetch;
  logic [63:0] exp_pc;
  logic [63:0] addrq[$];
  int          dueq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic rr, input logic rv, input logic [31:0] rdata,
                     input logic ir, input logic rd, input logic [63:0] rpc,
                     input logic erv, input logic [63:0] eaddr, input logic eiv,
                     input logic [63:0] epc, input logic [31:0] einst);
    vec_t v;
    v.rst = r; v.rr = rr; v.rv = rv; v.rdata = rdata; v.ir = ir; v.rd = rd; v.rpc = rpc;
    v.e_rv = erv; v.e_addr = eaddr; v.e_iv = eiv; v.e_pc = epc; v.e_inst = einst;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] hsh(input logic [63:0] a);
    return a[31:0] ^ {a[15:0], a[31:16]} ^ 32'h3C5A_9E71;
  endfunction

  // One cycle against the memory model; mode 0 random, 1 forced redirect to tgt, 2 quiet drain
  task automatic rcycle(input int mode, input logic [63:0] tgt);
    logic        rr, ir, rd;
    logic [63:0] t;
    int          sz0, due;
    @(negedge clk);
    cyc++;
    rr = (mode == 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
    ir = (mode == 2) ? 1'b1 : ($urandom_range(0, 2) != 0);
    rd = (mode == 1) || (mode == 0 && $urandom_range(0, 15) == 0);
    t  = (mode == 1) ? tgt : (B | 64'($urandom_range(0, 32'hFFF)));
    bus.imem_req_ready  = rr;
    bus.inst_ready      = ir;
    bus.redirect_valid  = rd;
    bus.redirect_pc     = t;
    bus.imem_resp_valid = (addrq.size() > 0) && (dueq[0] <= cyc);
    bus.imem_resp_data  = (addrq.size() > 0) ? hsh(addrq[0]) : 32'h0;
    #1;
    sz0 = addrq.size();
    if (bus.imem_resp_valid) begin
      void'(addrq.pop_front());
      void'(dueq.pop_front());
    end
    if (rd) chk("inst_valid_in_redirect", 64'(bus.inst_valid), 64'd0);
    if (bus.inst_valid && ir) begin
      chk("stream_pc", bus.inst_pc, exp_pc);
      chk("stream_inst", 64'(bus.inst), 64'(hsh(exp_pc)));
      exp_pc += 64'd4;
      pops++;
    end
    if (bus.imem_req_valid && rr) begin
      chk("req_addr", bus.imem_req_addr, exp_fetch);
      chk("credit_limit", 64'(sz0 < 2), 64'd1);
      due = cyc + 1 + int'($urandom_range(0, 2));
      if (dueq.size() > 0 && due < dueq[$]) due = dueq[$];
      addrq.push_back(bus.imem_req_addr);
      dueq.push_back(due);
      exp_fetch += 64'd4;
    end
    if (rd) begin
      exp_fetch = t & ~64'd3;
      exp_pc    = t & ~64'd3;
    end
  endtask

  initial begin
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.inst_ready      = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;

    //  rst rr rv rdata          ir rd rpc        | e_rv e_addr     e_iv e_pc      e_inst
    add(1, 0, 0, 32'h0,          0, 0, 64'h0,       0, B,          0, 64'h0,     32'h0);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       1, B,          0, 64'h0,     32'h0);
    add(0, 1, 1, 32'h1111_0000,  0, 0, 64'h0,       1, B+64'h4,    0, 64'h0,     32'h0);
    add(0, 1, 1, 32'h2222_0001,  0, 0, 64'h0,       0, B+64'h8,    1, B,         32'h1111_0000);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       0, B+64'h8,    1, B,         32'h1111_0000);
    add(0, 1, 0, 32'h0,          1, 0, 64'h0,       0, B+64'h8,    1, B,         32'h1111_0000);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       1, B+64'h8,    1, B+64'h4,   32'h2222_0001);
    add(0, 1, 1, 32'h3333_0002,  1, 0, 64'h0,       0, B+64'hC,    1, B+64'h4,   32'h2222_0001);
    add(0, 0, 0, 32'h0,          0, 0, 64'h0,       1, B+64'hC,    1, B+64'h8,   32'h3333_0002);
    add(0, 1, 0, 32'h0,          1, 0, 64'h0,       1, B+64'hC,    1, B+64'h8,   32'h3333_0002);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       1, B+64'h10,   0, 64'h0,     32'h0);
    add(0, 1, 0, 32'h0,          0, 1, B+64'h103,   0, B+64'h14,   0, 64'h0,     32'h0);
    add(0, 1, 1, 32'hBAD0_0001,  0, 0, 64'h0,       0, B+64'h100,  0, 64'h0,     32'h0);
    add(0, 1, 1, 32'hBAD0_0002,  0, 0, 64'h0,       1, B+64'h100,  0, 64'h0,     32'h0);
    add(0, 0, 1, 32'h4444_0003,  0, 0, 64'h0,       1, B+64'h104,  0, 64'h0,     32'h0);
    add(0, 0, 0, 32'h0,          1, 0, 64'h0,       1, B+64'h104,  1, B+64'h100, 32'h4444_0003);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       1, B+64'h104,  0, 64'h0,     32'h0);
    add(0, 1, 1, 32'hBAD0_0003,  1, 1, B+64'h200,   1, B+64'h108,  0, 64'h0,     32'h0);
    add(0, 1, 1, 32'hBAD0_0004,  0, 0, 64'h0,       1, B+64'h200,  0, 64'h0,     32'h0);
    add(0, 0, 1, 32'h5555_0004,  0, 0, 64'h0,       1, B+64'h204,  0, 64'h0,     32'h0);
    add(0, 0, 0, 32'h0,          1, 0, 64'h0,       1, B+64'h204,  1, B+64'h200, 32'h5555_0004);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       1, B+64'h204,  0, 64'h0,     32'h0);
    add(0, 1, 0, 32'h0,          0, 0, 64'h0,       1, B+64'h208,  0, 64'h0,     32'h0);
    add(1, 0, 1, 32'hBAD0_0005,  0, 0, 64'h0,       0, B+64'h20C,  0, 64'h0,     32'h0);
    add(0, 0, 1, 32'hBAD0_0006,  0, 0, 64'h0,       1, B,          0, 64'h0,     32'h0);
    add(0, 1, 1, 32'hBAD0_0007,  0, 0, 64'h0,       1, B,          0, 64'h0,     32'h0);
    add(0, 0, 1, 32'h6666_0005,  0, 0, 64'h0,       1, B+64'h4,    0, 64'h0,     32'h0);
    add(0, 0, 0, 32'h0,          1, 0, 64'h0,       1, B+64'h4,    1, B,         32'h6666_0005);

    repeat (2) @(posedge clk);

    // Directed cycle-exact table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      cyc++;
      rst                 = tbl[i].rst;
      bus.imem_req_ready  = tbl[i].rr;
      bus.imem_resp_valid = tbl[i].rv;
      bus.imem_resp_data  = tbl[i].rdata;
      bus.inst_ready      = tbl[i].ir;
      bus.redirect_valid  = tbl[i].rd;
      bus.redirect_pc     = tbl[i].rpc;
      #1;
      chk($sformatf("row%0d_req_valid", i), 64'(bus.imem_req_valid), 64'(tbl[i].e_rv));
      chk($sformatf("row%0d_req_addr", i), bus.imem_req_addr, tbl[i].e_addr);
      chk($sformatf("row%0d_inst_valid", i), 64'(bus.inst_valid), 64'(tbl[i].e_iv));
      if (tbl[i].e_iv || tbl[i].rst) begin
        chk($sformatf("row%0d_inst_pc", i), bus.inst_pc, tbl[i].e_pc);
        chk($sformatf("row%0d_inst", i), 64'(bus.inst), 64'(tbl[i].e_inst));
      end
    end

    // Model state after the table: empty FIFO, nothing in flight, next fetch at B+4
    exp_fetch = B + 64'h4;
    exp_pc    = B + 64'h4;

    // Back-to-back redirects: the second target must win
    rcycle(2, 64'h0);
    rcycle(2, 64'h0);
    rcycle(1, B + 64'h300);
    rcycle(1, B + 64'h401);
    for (int i = 0; i < 12; i++) rcycle(2, 64'h0);
    chk("b2b_redirect_stream_pos", 64'(exp_pc > B + 64'h400 && exp_pc < B + 64'h500), 64'd1);

    // Randomized traffic, then a quiet drain
    for (int i = 0; i < 3000; i++) rcycle(0, 64'h0);
    for (int i = 0; i < 40; i++) rcycle(2, 64'h0);
    chk("liveness_pops", 64'(pops > 300), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
